// File: rtl/machine_sched_pkg.sv
// Shared sizing constants and types for the context scheduler.
// Widths follow the shared Machine_cpu step function.
package machine_sched_pkg;
  localparam int NCTX = 4;
  localparam int IW   = 12;
  localparam int SW   = 8;
  localparam int OW   = 25;
  localparam int CTXW = $clog2(NCTX);

  typedef logic [CTXW-1:0] ctx_t;
  typedef logic [SW-1:0]   state_t;
endpackage

// File: rtl/machine_ctx_sched_rr_arb.sv
// Combinational round-robin picker.
// Searches elig starting at ptr, wrapping modulo NCTX.
module rr_arb
  import machine_sched_pkg::*;
(
  input  logic [NCTX-1:0] elig,
  input  ctx_t            ptr,
  output logic [NCTX-1:0] grant_onehot,
  output ctx_t            grant_idx,
  output logic            any
);

  logic [NCTX-1:0] rot;
  ctx_t            off_idx;

  // rot[i] is the eligibility of the context i places after ptr
  for (genvar gi = 0; gi < NCTX; gi++) begin : g_rot
    ctx_t idx;
    assign idx     = ptr + ctx_t'(gi);
    assign rot[gi] = elig[idx];
  end

  always_comb begin
    off_idx = '0;
    for (int i = NCTX - 1; i >= 0; i--) begin
      if (rot[i]) off_idx = ctx_t'(i);
    end
    grant_idx    = ptr + off_idx;
    any          = |elig;
    grant_onehot = '0;
    if (any) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/machine_ctx_sched.sv
// Time-shares one combinational CPU step function between NCTX contexts,
// keeping a private machine state per context and one registered result slot.
module machine_ctx_sched
  import machine_sched_pkg::*;
(
  input  logic                 system1000,
  input  logic                 system1000_rst,
  input  logic [NCTX-1:0]      req_valid,
  input  logic [NCTX*IW-1:0]   req_data,
  output logic [NCTX-1:0]      req_ready,
  input  logic [NCTX-1:0]      ctx_clr,
  output logic [SW-1:0]        cpu_s,
  output logic [IW-1:0]        cpu_i,
  input  logic [SW+OW-1:0]     cpu_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OW-1:0]        res_data,
  output logic [CTXW-1:0]      res_ctx
);

  state_t          st_reg [NCTX];
  ctx_t            ptr_reg;
  logic            free;
  logic [NCTX-1:0] elig;
  logic [NCTX-1:0] grant_onehot;
  ctx_t            grant_idx;
  logic            grant_any;
  state_t          next_state;
  logic [OW-1:0]   next_out;

  assign free = !res_valid || res_ready;
  // A clearing context is masked so a clear can never race a write-back.
  assign elig = req_valid & ~ctx_clr & {NCTX{free && !system1000_rst}};

  rr_arb u_arb (
    .elig         (elig),
    .ptr          (ptr_reg),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  assign req_ready  = grant_onehot;
  assign next_state = cpu_result[SW+OW-1:OW];
  assign next_out   = cpu_result[OW-1:0];

  always_comb begin
    cpu_s = st_reg[ptr_reg];
    cpu_i = '0;
    if (grant_any) begin
      cpu_s = st_reg[grant_idx];
      cpu_i = req_data[grant_idx*IW +: IW];
    end
  end

  for (genvar gi = 0; gi < NCTX; gi++) begin : g_state
    always_ff @(posedge system1000) begin
      if (system1000_rst || ctx_clr[gi]) begin
        st_reg[gi] <= '0;
      end else if (grant_onehot[gi]) begin
        st_reg[gi] <= next_state;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      ptr_reg   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ctx   <= '0;
    end else if (grant_any) begin
      ptr_reg   <= grant_idx + ctx_t'(1);
      res_valid <= 1'b1;
      res_data  <= next_out;
      res_ctx   <= grant_idx;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_machine_ctx_sched.sv
// Randomized and directed checks of machine_ctx_sched against a
// behavioural model of contexts, round-robin pointer and result slot.
module tb_machine_ctx_sched;
  import machine_sched_pkg::*;

  logic                system1000 = 1'b0;
  logic                system1000_rst;
  logic [NCTX-1:0]     req_valid;
  logic [NCTX*IW-1:0]  req_data;
  logic [NCTX-1:0]     req_ready;
  logic [NCTX-1:0]     ctx_clr;
  logic [SW-1:0]       cpu_s;
  logic [IW-1:0]       cpu_i;
  logic [SW+OW-1:0]    cpu_result;
  logic                res_valid;
  logic                res_ready;
  logic [OW-1:0]       res_data;
  logic [CTXW-1:0]     res_ctx;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_st [NCTX];
  int          m_ptr;
  logic        m_rv;
  logic [24:0] m_rd;
  logic [1:0]  m_rc;
  logic [3:0]  seen_ready;

  machine_ctx_sched dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .ctx_clr        (ctx_clr),
    .cpu_s          (cpu_s),
    .cpu_i          (cpu_i),
    .cpu_result     (cpu_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_ctx        (res_ctx)
  );

  // CPU stub: next state = s + i[7:0], output = {5'b0, s, i}
  logic [7:0] stub_next;
  assign stub_next  = cpu_s + cpu_i[7:0];
  assign cpu_result = {stub_next, 5'b0, cpu_s, cpu_i};

  initial forever #5 system1000 = ~system1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] rv, input logic [3:0] clr,
                                     input logic rr, input logic rst);
    if (rst || (m_rv && !rr)) return -1;
    for (int off = 0; off < NCTX; off++) begin
      int k = (m_ptr + off) % NCTX;
      if (rv[k] && !clr[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCTX; k++) m_st[k] = '0;
    m_ptr = 0; m_rv = 1'b0; m_rd = '0; m_rc = '0;
  endtask

  task automatic step(input logic [3:0] rv, input logic [47:0] rd, input logic [3:0] clr,
                      input logic rr, input logic rst);
    int g;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_s;
    logic [11:0] exp_i;
    @(negedge system1000);
    req_valid = rv; req_data = rd; ctx_clr = clr; res_ready = rr; system1000_rst = rst;
    #1;
    g = model_grant(rv, clr, rr, rst);
    exp_ready = '0;
    exp_s = m_st[m_ptr];
    exp_i = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      exp_s = m_st[g];
      exp_i = rd[g*12 +: 12];
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("cpu_s", 64'(cpu_s), 64'(exp_s));
    chk("cpu_i", 64'(cpu_i), 64'(exp_i));
    seen_ready = req_ready;
    @(posedge system1000);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NCTX; k++) if (clr[k]) m_st[k] = '0;
      if (g >= 0) begin
        m_rd  = {5'b0, m_st[g], rd[g*12 +: 12]};
        m_st[g] = m_st[g] + rd[g*12 +: 8];
        m_rc  = 2'(g);
        m_rv  = 1'b1;
        m_ptr = (g + 1) % NCTX;
      end else if (rr) begin
        m_rv = 1'b0;
      end
    end
    #1;
    chk("res_valid", 64'(res_valid), 64'(m_rv));
    chk("res_data", 64'(res_data), 64'(m_rd));
    chk("res_ctx", 64'(res_ctx), 64'(m_rc));
    $display("step rv=%b clr=%b rr=%b rst=%b grant=%b res_v=%b ctx=%0d data=%h",
             rv, clr, rr, rst, seen_ready, res_valid, res_ctx, res_data);
  endtask

  function automatic logic [47:0] all_data(input logic [11:0] d0, input logic [11:0] d1,
                                           input logic [11:0] d2, input logic [11:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    logic [24:0] held_data;
    logic [1:0]  held_ctx;
    req_valid = '0; req_data = '0; ctx_clr = '0; res_ready = 1'b1; system1000_rst = 1'b1;
    repeat (2) @(posedge system1000);
    @(negedge system1000);
    model_reset();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_ctx", 64'(res_ctx), 64'(0));
    chk("rst_cpu_s", 64'(cpu_s), 64'(0));
    chk("rst_cpu_i", 64'(cpu_i), 64'(0));

    // Single request on context 0
    step(4'b0000, '0, '0, 1'b1, 1'b1);
    step(4'b0001, all_data(12'h005, 0, 0, 0), '0, 1'b1, 1'b0);
    chk("single_grant", 64'(seen_ready), 64'(4'b0001));
    chk("single_data", 64'(res_data), 64'(25'h0000005));
    chk("single_ctx", 64'(res_ctx), 64'(0));
    step(4'b0001, all_data(12'h005, 0, 0, 0), '0, 1'b1, 1'b0);
    chk("repeat_data", 64'(res_data), 64'({5'b0, 8'h05, 12'h005}));

    // All four continuously, round-robin order
    step(4'b0000, '0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 8; n++) begin
      step(4'b1111, all_data(1, 2, 3, 4), '0, 1'b1, 1'b0);
      chk("rr_order", 64'(res_ctx), 64'(n % NCTX));
    end
    for (int k = 0; k < NCTX; k++) begin
      logic [3:0] one;
      one = '0; one[k] = 1'b1;
      step(one, '0, '0, 1'b1, 1'b0);
      chk("rr_state", 64'(res_data[19:12]), 64'(2 * (k + 1)));
    end

    // Backpressure
    step(4'b1111, all_data(7, 8, 9, 10), '0, 1'b1, 1'b0);
    held_data = res_data; held_ctx = res_ctx;
    for (int n = 0; n < 3; n++) begin
      step(4'b1111, all_data(7, 8, 9, 10), '0, 1'b0, 1'b0);
      chk("bp_no_grant", 64'(seen_ready), 64'(0));
      chk("bp_data_hold", 64'(res_data), 64'(held_data));
      chk("bp_ctx_hold", 64'(res_ctx), 64'(held_ctx));
    end
    step(4'b1111, all_data(7, 8, 9, 10), '0, 1'b1, 1'b0);
    chk("bp_resume", 64'(seen_ready != 0), 64'(1));

    // Clear collides with a request
    step(4'b0000, '0, '0, 1'b1, 1'b1);
    step(4'b0100, all_data(0, 0, 12'h010, 0), '0, 1'b1, 1'b0);
    step(4'b0100, all_data(0, 0, 12'h001, 0), 4'b0100, 1'b1, 1'b0);
    chk("clr_no_grant", 64'(seen_ready), 64'(0));
    step(4'b0100, all_data(0, 0, 12'h003, 0), '0, 1'b1, 1'b0);
    chk("clr_result", 64'(res_data), 64'({5'b0, 8'h00, 12'h003}));

    // Wrap and skip: pointer at 3 after granting context 2
    step(4'b0011, all_data(12'h021, 12'h022, 0, 0), '0, 1'b1, 1'b0);
    chk("wrap_grant0", 64'(seen_ready), 64'(4'b0001));
    step(4'b0011, all_data(12'h021, 12'h022, 0, 0), '0, 1'b1, 1'b0);
    chk("wrap_ptr1", 64'(seen_ready), 64'(4'b0010));

    // Reset mid-stream
    step(4'b1111, all_data(1, 1, 1, 1), '0, 1'b1, 1'b0);
    step(4'b1111, all_data(1, 1, 1, 1), '0, 1'b1, 1'b1);
    chk("midrst_no_grant", 64'(seen_ready), 64'(0));
    chk("midrst_res_valid", 64'(res_valid), 64'(0));
    step(4'b0000, '0, '0, 1'b0, 1'b0);
    chk("midrst_state", 64'(cpu_s), 64'(0));
    chk("midrst_no_result", 64'(res_valid), 64'(0));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rv, clr;
      logic rr, rst;
      rv  = 4'($urandom);
      clr = 4'($urandom & $urandom & $urandom);
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      step(rv, {16'($urandom), 32'($urandom)}, clr, rr, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
